// File: rtl/ser_link_tx_pkg.sv
// Shared definitions for the serial NoC link: system flit width, the
// line-state encodings (also decoded by the peer serial receiver) and the
// even-parity helper used to build the frame trailer bit.
`ifndef HDR_SZ
`define HDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

package ser_link_tx_pkg;

    // Flit width used throughout the NoC: header + payload + address.
    localparam int FLIT_W_SYS = `HDR_SZ + `PL_SZ + `ADDR_SZ;

    // Widest flit the parity helper can fold.
    localparam int PAR_MAX_W = 64;

    // Line states; the 3-bit encoding is shared with the serial receiver.
    typedef enum logic [2:0] {
        SER_IDLE   = 3'd0,
        SER_START  = 3'd1,
        SER_DATA   = 3'd2,
        SER_PARITY = 3'd3,
        SER_GAP    = 3'd4
    } ser_state_e;

    // Even parity: XOR of all bits. Narrower flits are zero-extended,
    // which leaves the XOR unchanged.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/ser_tx_buf.sv
// Two-entry flit buffer for the serial link transmitter.
//   SR (shift register slot) holds the flit currently being framed;
//   HR (holding register) holds the next one.
// Ports:
//   clk, reset      - link clock, synchronous active-high reset
//   item_i, valid_i - upstream flit and its valid
//   fsm_idle_i      - framer is in IDLE (direct load into SR allowed)
//   sr_release_i    - SR frees on this edge (frame and forced gap done)
//   busy_o          - HR full, no flit can be accepted (registered)
//   sr_full_o       - SR holds a flit waiting for / in transmission
//   sr_data_o       - flit in SR
module ser_tx_buf
    import ser_link_tx_pkg::*;
#(
    parameter int unsigned FLIT_W = FLIT_W_SYS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] item_i,
    input  logic              valid_i,
    input  logic              fsm_idle_i,
    input  logic              sr_release_i,
    output logic              busy_o,
    output logic              sr_full_o,
    output logic [FLIT_W-1:0] sr_data_o
);

    logic              hr_full_q, hr_full_d;
    logic              sr_full_q, sr_full_d;
    logic [FLIT_W-1:0] hr_data_q, hr_data_d;
    logic [FLIT_W-1:0] sr_data_q, sr_data_d;
    logic              accept;
    logic              sr_open;

    // Next-state of both slots: HR refills SR first, then a new flit lands
    // in SR (only when the framer is idle and SR empty) or else in HR.
    always_comb begin
        accept    = valid_i && !hr_full_q;
        sr_open   = !sr_full_q || sr_release_i;
        hr_full_d = hr_full_q;
        hr_data_d = hr_data_q;
        sr_full_d = sr_full_q;
        sr_data_d = sr_data_q;
        if (sr_open && hr_full_q) begin
            // HR full means busy was high, so no accept can coincide here.
            sr_full_d = 1'b1;
            sr_data_d = hr_data_q;
            hr_full_d = 1'b0;
        end else if (accept && !sr_full_q && fsm_idle_i) begin
            sr_full_d = 1'b1;
            sr_data_d = item_i;
        end else if (accept) begin
            // Includes the edge SR frees with HR empty: the flit parks in HR
            // and moves to the empty SR on the following edge.
            hr_full_d = 1'b1;
            hr_data_d = item_i;
            sr_full_d = sr_full_q && !sr_release_i;
        end else begin
            sr_full_d = sr_full_q && !sr_release_i;
        end
    end

    // Slot registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr_full_q <= 1'b0;
            sr_full_q <= 1'b0;
            hr_data_q <= '0;
            sr_data_q <= '0;
        end else begin
            hr_full_q <= hr_full_d;
            sr_full_q <= sr_full_d;
            hr_data_q <= hr_data_d;
            sr_data_q <= sr_data_d;
        end
    end

    assign busy_o    = hr_full_q;
    assign sr_full_o = sr_full_q;
    assign sr_data_o = sr_data_q;

endmodule

// File: rtl/ser_link_tx.sv
// Serial link transmitter for one router output direction.
// Frames each flit as: start bit (1), FLIT_W data bits LSB first, optional
// even-parity bit, then low idle time before the next start bit.
// Ports:
//   clk, reset  - link clock, synchronous active-high reset
//   item_in     - flit from the router output stage / NI
//   valid       - item_in valid; held by upstream while busy
//   busy        - no flit can be accepted this cycle
//   ser_data    - serial line, idle low, registered
//   ser_busy    - downstream receiver cannot take a new frame
//   active      - frame or forced gap in progress
//   flit_count  - frames completely sent, wraps modulo 2^20
module ser_link_tx
    import ser_link_tx_pkg::*;
#(
    parameter int unsigned FLIT_W    = FLIT_W_SYS,
    parameter bit          PARITY_EN = 1'b1,
    parameter int unsigned GAP       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] item_in,
    input  logic              valid,
    output logic              busy,
    output logic              ser_data,
    input  logic              ser_busy,
    output logic              active,
    output logic [19:0]       flit_count
);

    localparam int unsigned     CNT_W    = $clog2(FLIT_W);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FLIT_W - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // The mandatory IDLE cycle (SR-full check) is itself a low line cycle,
    // so it counts as the first gap cycle. A GAP state is only needed for
    // the remaining GAP-1 cycles; GAP of 0 or 1 goes straight to IDLE.
    localparam bit               GAP_STATE_EN = (GAP > 1);
    localparam logic [2:0]       GAP_LOAD     = GAP_STATE_EN ? 3'(GAP - 2) : 3'd0;

    ser_state_e        state_q;
    logic [FLIT_W-1:0] shift_q;
    logic [CNT_W-1:0]  bit_idx_q;
    logic [2:0]        gap_cnt_q;
    logic              parity_q;
    logic              ser_data_q;
    logic              active_q;
    logic [19:0]       flit_count_q;

    logic              sr_full;
    logic [FLIT_W-1:0] sr_data;
    logic              sr_release;
    logic              fsm_idle;

    ser_tx_buf #(
        .FLIT_W (FLIT_W)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .item_i       (item_in),
        .valid_i      (valid),
        .fsm_idle_i   (fsm_idle),
        .sr_release_i (sr_release),
        .busy_o       (busy),
        .sr_full_o    (sr_full),
        .sr_data_o    (sr_data)
    );

    // SR is released on the edge that ends the low time owned by the frame.
    always_comb begin
        fsm_idle   = (state_q == SER_IDLE);
        sr_release = 1'b0;
        case (state_q)
            SER_DATA:   sr_release = (bit_idx_q == LAST_IDX) && !PARITY_EN && !GAP_STATE_EN;
            SER_PARITY: sr_release = !GAP_STATE_EN;
            SER_GAP:    sr_release = (gap_cnt_q == 3'd0);
            default:    sr_release = 1'b0;
        endcase
    end

    // Framer FSM with shifter, bit/gap counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SER_IDLE;
            shift_q      <= '0;
            bit_idx_q    <= '0;
            gap_cnt_q    <= 3'd0;
            parity_q     <= 1'b0;
            ser_data_q   <= 1'b0;
            active_q     <= 1'b0;
            flit_count_q <= 20'd0;
        end else begin
            case (state_q)
                SER_IDLE: begin
                    // ser_busy is only looked at here; a started frame always completes.
                    if (sr_full && !ser_busy) begin
                        state_q    <= SER_START;
                        ser_data_q <= 1'b1;
                        active_q   <= 1'b1;
                        shift_q    <= sr_data;
                        parity_q   <= even_parity(PAR_MAX_W'(sr_data));
                    end else begin
                        ser_data_q <= 1'b0;
                        active_q   <= 1'b0;
                    end
                end
                SER_START: begin
                    state_q    <= SER_DATA;
                    ser_data_q <= shift_q[0];
                    shift_q    <= {1'b0, shift_q[FLIT_W-1:1]};
                    bit_idx_q  <= '0;
                end
                SER_DATA: begin
                    if (bit_idx_q != LAST_IDX) begin
                        ser_data_q <= shift_q[0];
                        shift_q    <= {1'b0, shift_q[FLIT_W-1:1]};
                        bit_idx_q  <= bit_idx_q + IDX_ONE;
                    end else if (PARITY_EN) begin
                        state_q    <= SER_PARITY;
                        ser_data_q <= parity_q;
                    end else if (GAP_STATE_EN) begin
                        state_q      <= SER_GAP;
                        gap_cnt_q    <= GAP_LOAD;
                        ser_data_q   <= 1'b0;
                        flit_count_q <= flit_count_q + 20'd1;
                    end else begin
                        state_q      <= SER_IDLE;
                        ser_data_q   <= 1'b0;
                        active_q     <= 1'b0;
                        flit_count_q <= flit_count_q + 20'd1;
                    end
                end
                SER_PARITY: begin
                    ser_data_q   <= 1'b0;
                    flit_count_q <= flit_count_q + 20'd1;
                    if (GAP_STATE_EN) begin
                        state_q   <= SER_GAP;
                        gap_cnt_q <= GAP_LOAD;
                    end else begin
                        state_q  <= SER_IDLE;
                        active_q <= 1'b0;
                    end
                end
                SER_GAP: begin
                    ser_data_q <= 1'b0;
                    if (gap_cnt_q == 3'd0) begin
                        state_q  <= SER_IDLE;
                        active_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q    <= SER_IDLE;
                    ser_data_q <= 1'b0;
                    active_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ser_data   = ser_data_q;
    assign active     = active_q;
    assign flit_count = flit_count_q;

endmodule
